// File: rtl/tx_framer_pkg.sv
// tx_framer_pkg: shared constants and types for the frame builder.
//   CRC32_POLY_R / CRC32_INIT / CRC32_XOROUT : reflected IEEE CRC-32 parameters
//   DEF_PRE_PATTERN / DEF_SYNC_WORD          : default preamble and header sync
//   framer_state_e                           : framer FSM encoding
package tx_framer_pkg;

    localparam logic [31:0] CRC32_POLY_R    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT    = 32'hFFFF_FFFF;

    localparam logic [31:0] DEF_PRE_PATTERN = 32'hCCCC_CCCC;
    localparam logic [15:0] DEF_SYNC_WORD   = 16'hA5F0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_PAY,
        ST_CRC
    } framer_state_e;

endpackage

// File: rtl/tx_framer_if.sv
// tx_framer_if: control, upstream payload and mapper-side word handshake.
//   start/len               : frame request and payload word count
//   pay_valid/pay_data      : upstream word source, pay_ack consumes a word
//   valid_o/data_o/ack_o    : framed word to the mapper (transfer = valid_o & ack_o)
//   busy/done               : framer status
// Modport slave is the framer; master is the surrounding environment.
interface tx_framer_if #(
    parameter int unsigned LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             pay_valid;
    logic [31:0]      pay_data;
    logic             pay_ack;
    logic             valid_o;
    logic [31:0]      data_o;
    logic             ack_o;
    logic             busy;
    logic             done;

    modport master (
        output start, len, pay_valid, pay_data, ack_o,
        input  pay_ack, valid_o, data_o, busy, done
    );

    modport slave (
        input  start, len, pay_valid, pay_data, ack_o,
        output pay_ack, valid_o, data_o, busy, done
    );
endinterface

// File: rtl/tx_framer_crc32_word.sv
// crc32_word: combinational 32-bit-parallel step of the reflected CRC-32.
//   crc_i : running CRC register
//   d_i   : data word, consumed byte 0 first, LSB first (i.e. bit 0 .. bit 31)
//   crc_o : CRC register after absorbing d_i
module crc32_word
    import tx_framer_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [31:0] d_i,
    output logic [31:0] crc_o
);
    logic [31:0] c;
    logic        fb;

    always_comb begin
        c  = crc_i;
        fb = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            fb = c[0] ^ d_i[i];
            c  = {1'b0, c[31:1]} ^ (fb ? CRC32_POLY_R : '0);
        end
        crc_o = c;
    end
endmodule

// File: rtl/tx_framer.sv
// tx_framer: builds frames of PRE_WORDS preamble words, one header word
// {SYNC_WORD, len}, len payload words and one CRC-32 word over the payload.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : tx_framer_if slave (start/len, payload source, mapper output,
//              busy/done)
// The output is a single register reloaded whenever it is empty or its word
// is being acked (load = !valid_o | ack_o).
module tx_framer
    import tx_framer_pkg::*;
#(
    parameter int unsigned PRE_WORDS   = 2,
    parameter logic [31:0] PRE_PATTERN = DEF_PRE_PATTERN,
    parameter logic [15:0] SYNC_WORD   = DEF_SYNC_WORD,
    parameter int unsigned LEN_W       = 16
) (
    input  logic       CLK,
    input  logic       RST,
    tx_framer_if.slave bus
);
    localparam int unsigned      PRE_CW   = (PRE_WORDS > 1) ? $clog2(PRE_WORDS) : 1;
    localparam int unsigned      CNT_W    = (LEN_W > PRE_CW) ? LEN_W : PRE_CW;
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_WORDS - 1);

    framer_state_e    state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      crc_q, crc_d;
    logic             valid_q, valid_d;
    logic [31:0]      data_q, data_d;
    logic             done_q, done_d;
    logic             crc_sent_q, crc_sent_d;

    logic             load;
    logic             pay_ack;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      crc_next;

    crc32_word u_crc (
        .crc_i (crc_q),
        .d_i   (bus.pay_data),
        .crc_o (crc_next)
    );

    assign load    = !valid_q || bus.ack_o;
    assign pay_ack = (state_q == ST_PAY) && load && bus.pay_valid;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            crc_q      <= CRC32_INIT;
            valid_q    <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            crc_sent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            done_q     <= done_d;
            crc_sent_q <= crc_sent_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        valid_d    = valid_q;
        data_d     = data_q;
        done_d     = 1'b0;
        crc_sent_d = crc_sent_q;

        // A loaded-but-not-refilled register empties; branches below refill it.
        if (load) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                // The accepting cycle already loads preamble word 0 so it is
                // visible on the very next cycle; cnt then indexes word 1.
                if (bus.start && load) begin
                    len_d      = bus.len;
                    crc_d      = CRC32_INIT;
                    crc_sent_d = 1'b0;
                    valid_d    = 1'b1;
                    data_d     = PRE_PATTERN;
                    if (PRE_WORDS == 1) begin
                        state_d = ST_HDR;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_PRE;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_PRE: begin
                if (load) begin
                    valid_d = 1'b1;
                    data_d  = PRE_PATTERN;
                    if (cnt_q == PRE_LAST) begin
                        state_d = ST_HDR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_HDR: begin
                if (load) begin
                    valid_d = 1'b1;
                    data_d  = {SYNC_WORD, 16'(len_q)};
                    cnt_d   = '0;
                    state_d = (len_q == '0) ? ST_CRC : ST_PAY;
                end
            end
            ST_PAY: begin
                if (pay_ack) begin
                    valid_d = 1'b1;
                    data_d  = bus.pay_data;
                    crc_d   = crc_next;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == CNT_W'(len_q)) begin
                        state_d = ST_CRC;
                    end
                end
            end
            ST_CRC: begin
                // crc_sent distinguishes loading the CRC word from waiting
                // for its ack; the frame ends only on that ack.
                if (!crc_sent_q) begin
                    if (load) begin
                        valid_d    = 1'b1;
                        data_d     = crc_q ^ CRC32_XOROUT;
                        crc_sent_d = 1'b1;
                    end
                end else if (valid_q && bus.ack_o) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    crc_sent_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.pay_ack = pay_ack;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_q;
endmodule
